// File: rtl/spi_tx_fifo_if.sv
// Handshake bundle between the register-bus push side, the SPI shifter pop side
// and the driver-visible level/threshold signals of spi_tx_fifo.
interface spi_tx_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
);
    logic                  clr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [CNT_W-1:0]      elements_o;
    logic [CNT_W-1:0]      thresh_i;
    logic                  thresh_irq_o;

    // The FIFO itself
    modport slave (
        input  clr_i, data_i, valid_i, ready_i, thresh_i,
        output ready_o, data_o, valid_o, elements_o, thresh_irq_o
    );

    // Whoever drives the FIFO (register bus + shifter, or a bench)
    modport master (
        output clr_i, data_i, valid_i, ready_i, thresh_i,
        input  ready_o, data_o, valid_o, elements_o, thresh_irq_o
    );
endinterface

// File: rtl/spi_tx_fifo.sv
// Word FIFO feeding the SPI transmit shifter: push from the register bus, pop on
// the shifter's valid/ready, with flush, fill level and a registered low-water flag.
module spi_tx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    spi_tx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  irq_reg, irq_next;
    logic [DEPTH-1:0]      wr_en;
    logic                  full, empty, push, pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Flush gates both handshakes so nothing is accepted or handed out while emptying
    assign bus.ready_o      = !bus.clr_i && !full;
    assign bus.valid_o      = !bus.clr_i && !empty;
    assign bus.data_o       = mem[rd_ptr_reg];
    assign bus.elements_o   = count_reg;
    assign bus.thresh_irq_o = irq_reg;

    assign push = bus.valid_i && bus.ready_o;
    assign pop  = bus.valid_o && bus.ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Storage is deliberately not reset; valid_o masks stale entries
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= bus.data_i;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (bus.clr_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    // Flag follows the post-update level so it lines up with elements_o
    always_comb begin
        irq_next = (count_next <= bus.thresh_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            irq_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            irq_reg    <= irq_next;
        end
    end
endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo: a queue model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_spi_tx_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    spi_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    spi_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words and the low-water flag
    logic [DW-1:0] mq[$];
    bit            m_irq = 1'b0;
    logic [DW-1:0] dut_popped[$];

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (rst) begin
            mq.delete();
            m_irq = 1'b0;
        end else if (bus.clr_i) begin
            mq.delete();
            m_irq = (0 <= int'(bus.thresh_i));
        end else begin
            do_push = bus.valid_i && (mq.size() < DEPTH);
            do_pop  = bus.ready_i && (mq.size() > 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(bus.data_i);
            m_irq = (mq.size() <= int'(bus.thresh_i));
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("check %s = %h", name, act);
        end
    endtask

    // Cycle compare against the model, and capture of DUT-side pops
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_ready, exp_valid;
            exp_ready = !bus.clr_i && (mq.size() != DEPTH);
            exp_valid = !bus.clr_i && (mq.size() != 0);
            total += 5;
            if (bus.ready_o !== exp_ready) begin
                bad++; $display("FAIL cyc_ready actual=%b required=%b", bus.ready_o, exp_ready);
            end
            if (bus.valid_o !== exp_valid) begin
                bad++; $display("FAIL cyc_valid actual=%b required=%b", bus.valid_o, exp_valid);
            end
            if (int'(bus.elements_o) != mq.size()) begin
                bad++; $display("FAIL cyc_elements actual=%0d required=%0d", bus.elements_o, mq.size());
            end
            if (bus.thresh_irq_o !== m_irq) begin
                bad++; $display("FAIL cyc_irq actual=%b required=%b", bus.thresh_irq_o, m_irq);
            end
            if (int'(bus.elements_o) > DEPTH) begin
                bad++; $display("FAIL cyc_overflow actual=%0d required<=%0d", bus.elements_o, DEPTH);
            end
            if (mq.size() > 0) begin
                total++;
                if (bus.data_o !== mq[0]) begin
                    bad++; $display("FAIL cyc_data actual=%h required=%h", bus.data_o, mq[0]);
                end
            end
            if (!rst && bus.valid_o && bus.ready_i) dut_popped.push_back(bus.data_o);
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        bus.clr_i   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.clr_i   = 1'b0;
    endtask

    task automatic chk_popped(input string name, input logic [DW-1:0] first, input int n);
        chk({name, "_n"}, DW'(dut_popped.size()), DW'(n));
        for (int i = 0; i < n && i < dut_popped.size(); i++)
            chk(name, dut_popped[i], first + DW'(i));
        dut_popped.delete();
    endtask

    initial begin
        bus.thresh_i = '0;
        bus.data_i   = '0;
        idle();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", DW'(bus.valid_o), 0);
        chk("rst_ready", DW'(bus.ready_o), 1);
        chk("rst_elements", DW'(bus.elements_o), 0);
        chk("rst_irq", DW'(bus.thresh_irq_o), 0);

        // Three pushes with the shifter stalled
        cyc(1, 32'h11111111, 0, 0);
        chk("s1_valid_rise", DW'(bus.valid_o), 1);
        chk("s1_head", bus.data_o, 32'h11111111);
        cyc(1, 32'h22222222, 0, 0);
        cyc(1, 32'h33333333, 0, 0);
        idle();
        chk("s1_elements", DW'(bus.elements_o), 3);
        chk("s1_head2", bus.data_o, 32'h11111111);

        // Drain them back-to-back
        dut_popped.delete();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        idle();
        chk("s2_valid", DW'(bus.valid_o), 0);
        chk("s2_elements", DW'(bus.elements_o), 0);
        chk("s2_w0", dut_popped[0], 32'h11111111);
        chk("s2_w1", dut_popped[1], 32'h22222222);
        chk("s2_w2", dut_popped[2], 32'h33333333);
        dut_popped.delete();

        // Fill to full, attempt a ninth push, drain
        for (int i = 0; i < 8; i++) cyc(1, 32'hA0 + i, 0, 0);
        idle();
        chk("s3_full_ready", DW'(bus.ready_o), 0);
        chk("s3_full_elements", DW'(bus.elements_o), 8);
        cyc(1, 32'hFF, 0, 0);
        idle();
        chk("s3_after_drop", DW'(bus.elements_o), 8);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        idle();
        chk_popped("s3_pop", 32'hA0, 8);

        // Steady-state streaming at level 4
        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + i, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 32'h104 + i, 1, 0);
        idle();
        chk("s4_level", DW'(bus.elements_o), 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        idle();
        chk_popped("s4_order", 32'h100, 24);

        // Wrap-around: full, drain one, refill
        for (int i = 0; i < 8; i++) cyc(1, 32'hB0 + i, 0, 0);
        cyc(0, 0, 1, 0);
        idle();
        chk("s4w_seven", DW'(bus.elements_o), 7);
        cyc(1, 32'hB8, 0, 0);
        idle();
        chk("s4w_refull", DW'(bus.elements_o), 8);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        idle();
        chk_popped("s4w_pop", 32'hB0, 9);

        // Flush with both handshakes requested
        for (int i = 0; i < 5; i++) cyc(1, 32'hC0 + i, 0, 0);
        bus.valid_i = 1'b1; bus.data_i = 32'hEE; bus.ready_i = 1'b1; bus.clr_i = 1'b1;
        #1;
        chk("s5_flush_ready", DW'(bus.ready_o), 0);
        chk("s5_flush_valid", DW'(bus.valid_o), 0);
        cyc(1, 32'hEE, 1, 1);
        idle();
        chk("s5_elements", DW'(bus.elements_o), 0);
        chk("s5_valid", DW'(bus.valid_o), 0);
        chk("s5_no_pop", DW'(dut_popped.size()), 0);

        // Low-water flag and mid-stream reset
        bus.thresh_i = CNT_W'(2);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'hD0 + i, 0, 0);
        idle();
        chk("s6_irq_at4", DW'(bus.thresh_irq_o), 0);
        cyc(0, 0, 1, 0);
        chk("s6_el3", DW'(bus.elements_o), 3);
        chk("s6_irq_at3", DW'(bus.thresh_irq_o), 0);
        cyc(0, 0, 1, 0);
        chk("s6_el2", DW'(bus.elements_o), 2);
        chk("s6_irq_at2", DW'(bus.thresh_irq_o), 1);
        for (int i = 0; i < 2; i++) cyc(1, 32'hD4 + i, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 1, 0);
        rst = 1'b0;
        idle();
        chk("s6_rst_irq", DW'(bus.thresh_irq_o), 0);
        chk("s6_rst_elements", DW'(bus.elements_o), 0);
        chk("s6_rst_valid", DW'(bus.valid_o), 0);
        dut_popped.delete();

        // Threshold at or above DEPTH keeps the flag set even when full
        bus.thresh_i = CNT_W'(15);
        for (int i = 0; i < 8; i++) cyc(1, 32'hE0 + i, 0, 0);
        idle();
        chk("s7_irq_full15", DW'(bus.thresh_irq_o), 1);
        bus.thresh_i = CNT_W'(8);
        cyc(0, 0, 0, 0);
        chk("s7_irq_full8", DW'(bus.thresh_irq_o), 1);
        bus.thresh_i = CNT_W'(7);
        cyc(0, 0, 0, 0);
        chk("s7_irq_full7", DW'(bus.thresh_irq_o), 0);
        cyc(0, 0, 0, 1);
        idle();
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_tx_fifo.md
Name: spi_tx_fifo

Overview:
Synchronous word FIFO directly upstream of the SPI transmit shifter. Register-bus writes of TX words are pushed in on one side. On the other side the FIFO presents words on a valid/ready interface that connects straight to the shifter's data/data_valid/data_ready inputs. It provides flush, a fill-level count and a programmable low-water interrupt so the driver can refill before the shifter runs dry.

Parameters:
DATA_WIDTH, 32, width of each stored word.
DEPTH, 8, number of entries; must be a power of two and at least 2.
CNT_W, $clog2(DEPTH)+1, width of the level and threshold fields (derived; do not override).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous reset, active-high.
clr_i  in  1  synchronous flush; empties the FIFO in one cycle.
data_i  in  DATA_WIDTH  push data.
valid_i  in  1  push request.
ready_o  out  1  push accept; a push occurs when valid_i && ready_o.
data_o  out  DATA_WIDTH  head word, driven to the shifter's data input.
valid_o  out  1  head word valid, driven to the shifter's data_valid.
ready_i  in  1  pop accept from the shifter's data_ready; a pop occurs when valid_o && ready_i.
elements_o  out  CNT_W  current number of stored words, 0..DEPTH.
thresh_i  in  CNT_W  low-water threshold.
thresh_irq_o  out  1  registered low-water flag.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array, write pointer, read pointer (log2(DEPTH) bits each) and a CNT_W-bit count. Pointers wrap naturally from DEPTH-1 to 0.
- Reset (rst=1 at a clk edge):
  - pointers=0, count=0, thresh_irq_o=0.
  - Array contents are not reset.
  - Outputs after reset: valid_o=0, ready_o=1, elements_o=0, data_o=don't-care.
  - rst has priority over clr_i and over any handshake. Reset mid-stream drops all stored words.
- Output gating:
  - ready_o = !clr_i && (count != DEPTH).
  - valid_o = !clr_i && (count != 0).
  - data_o = mem[rd_ptr]. This is a combinational read of registered state, with no fall-through path.
- Push: on a push, mem[wr_ptr] <= data_i and wr_ptr++.
- Pop: on a pop, rd_ptr++.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle.
- Latency:
  - A word pushed into an empty FIFO appears on valid_o/data_o the next cycle.
  - A pop frees space (ready_o rises) the next cycle.
- Full (count==DEPTH): ready_o=0 and the push is refused; data_i is ignored. A pop in the same cycle is still honoured, so ready_o=1 on the next cycle.
- Empty (count==0): valid_o=0, so no pop can occur. A push in the same cycle is honoured, so valid_o=1 on the next cycle.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count holds. At count==1 the popped word is the old head and the new word becomes the head next cycle.
- Flush (clr_i=1 without rst):
  - Pointers and count go to 0 at the edge.
  - ready_o and valid_o are forced 0 during the flush cycle, so no handshake is taken or lost.
  - thresh_irq_o updates as normal on the following cycle.
- elements_o = count (registered value).
- thresh_irq_o is registered: it takes the value (next_count <= thresh_i) each cycle, where next_count is the post-update count. It therefore matches elements_o <= thresh_i in the same cycle that elements_o changes.
- thresh_i is sampled every cycle; a change reflects on thresh_irq_o on the next edge.
- thresh_i >= DEPTH keeps thresh_irq_o=1 permanently (outside reset).
- No overflow or underflow is possible by construction. The bench asserts count never exceeds DEPTH.

Test Plan:
- Reset, then push 0x11111111, 0x22222222, 0x33333333 with ready_i=0 -> valid_o rises one cycle after the first push; data_o=0x11111111; elements_o=3.
- Continuing from the previous scenario, ready_i=1 held, no pushes -> data_o sequence 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; valid_o=0 after the third pop; elements_o=0.
- DEPTH=8: push 8 words 0xA0..0xA7 with ready_i=0 -> ready_o=0 at elements_o=8. A 9th push of 0xFF is dropped. Then pop all 8 -> exactly 0xA0..0xA7 with no 0xFF.
- Fill with 4 words, then valid_i=1 and ready_i=1 continuously for 20 cycles with an incrementing pattern -> elements_o stays 4 and output order matches input order. Separately, fill to 8, drain to 7, refill to 8 -> wrap-around verified.
- Fill with 5 words, assert clr_i for 1 cycle with valid_i=1 and ready_i=1 -> ready_o=0 and valid_o=0 during that cycle. Next cycle elements_o=0, valid_o=0 and the stale head is not presented.
- thresh_i=2, fill to 4, then pop one per cycle -> thresh_irq_o=0 at counts 4 and 3 and goes 1 in the cycle elements_o becomes 2. Apply rst mid-sequence -> thresh_irq_o=0 and elements_o=0 immediately after the edge.
